// File: rtl/hit_detector.sv
// rtl/hit_detector.sv - button synchronizer, debouncer and hit/miss verdict stage
module hit_detector #(
    parameter int N_MOLES         = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_MOLES-1:0] btn,
    input  logic [N_MOLES-1:0] mole_onehot,
    input  logic               mole_valid,
    output logic               hit,
    output logic               miss,
    output logic [N_MOLES-1:0] btn_db
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_MOLES-1:0] sync1;
    logic [N_MOLES-1:0] sample;
    logic [N_MOLES-1:0] db_next;
    logic [N_MOLES-1:0] press_q;
    logic [N_MOLES-1:0] mole_q;
    logic [CW-1:0]      cnt [N_MOLES];
    logic               locked;
    logic               any_press;
    logic               good;
    logic               hit_d;
    logic               miss_d;
    logic               unlock;

    // The toggle fires on the cycle whose increment would reach DEBOUNCE_CYCLES.
    always_comb begin
        db_next = btn_db;
        for (int i = 0; i < N_MOLES; i++) begin
            if (sample[i] != btn_db[i] && cnt[i] == CNT_LAST)
                db_next[i] = ~btn_db[i];
        end
    end

    always_comb begin
        any_press = |press_q;
        good      = mole_valid && |(press_q & mole_onehot);
        hit_d     = any_press && !locked && good;
        miss_d    = any_press && !locked && !good;
        unlock    = !mole_valid || (mole_onehot != mole_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= '0;
            sample  <= '0;
            btn_db  <= '0;
            press_q <= '0;
            mole_q  <= '0;
            locked  <= 1'b0;
            hit     <= 1'b0;
            miss    <= 1'b0;
            for (int i = 0; i < N_MOLES; i++)
                cnt[i] <= '0;
        end else begin
            sync1   <= btn;
            sample  <= sync1;
            btn_db  <= db_next;
            press_q <= db_next & ~btn_db;
            mole_q  <= mole_onehot;
            hit     <= hit_d;
            miss    <= miss_d;
            for (int i = 0; i < N_MOLES; i++) begin
                if (sample[i] == btn_db[i] || cnt[i] == CNT_LAST)
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + 1'b1;
            end
            // A mole change or disappearance re-arms scoring, even over a fresh hit.
            if (unlock)
                locked <= 1'b0;
            else if (hit_d)
                locked <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hit_detector.sv
// tb/tb_hit_detector.sv - scoreboard bench for hit_detector
module tb_hit_detector;

    localparam int D = 4;

    typedef struct {
        bit is_hit;
        int at_edge;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic [3:0] mole_onehot;
    logic       mole_valid;
    logic       hit;
    logic       miss;
    logic [3:0] btn_db;

    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;
    exp_t sb[$];

    hit_detector #(.N_MOLES(4), .DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .mole_onehot (mole_onehot),
        .mole_valid  (mole_valid),
        .hit         (hit),
        .miss        (miss),
        .btn_db      (btn_db)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    always @(negedge clk) begin
        if (hit && miss) begin
            errors++;
            $display("FAIL hit_miss_both: hit=%0b miss=%0b required not both", hit, miss);
        end
        if (hit || miss) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: hit=%0b miss=%0b at edge %0d, none expected",
                         hit, miss, edge_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.is_hit != hit || e.at_edge != edge_cnt) begin
                    errors++;
                    $display("FAIL pulse: got hit=%0b at edge %0d, required hit=%0b at edge %0d",
                             hit, edge_cnt, e.is_hit, e.at_edge);
                end
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic wait_cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_mole(logic v, logic [3:0] oh);
        @(negedge clk);
        mole_valid  = v;
        mole_onehot = oh;
        wait_cyc(2);
    endtask

    // kind: 0 = no pulse, 1 = hit, 2 = miss; pulse lands D+3 edges after drive.
    task automatic press(logic [3:0] v, int kind);
        @(negedge clk);
        btn = v;
        if (kind != 0) sb.push_back('{kind == 1, edge_cnt + D + 3});
        wait_cyc(12);
        check("btn_db_after_press", 32'(btn_db), 32'(v));
    endtask

    task automatic release_all();
        @(negedge clk);
        btn = '0;
        wait_cyc(12);
        check("btn_db_after_release", 32'(btn_db), 32'd0);
    endtask

    initial begin
        reset       = 1'b0;
        btn         = '0;
        mole_onehot = '0;
        mole_valid  = 1'b0;
        wait_cyc(2);
        check("reset_hit", 32'(hit), 32'd0);
        check("reset_miss", 32'(miss), 32'd0);
        check("reset_btn_db", 32'(btn_db), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Clean hit
        set_mole(1'b1, 4'b0010);
        press(4'b0010, 1);
        release_all();

        // Bounce rejection, then a steady hold
        set_mole(1'b0, 4'b0010);
        set_mole(1'b1, 4'b0010);
        @(negedge clk);
        for (int r = 0; r < 5; r++) begin
            btn = 4'b0010;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                check("bounce_btn_db", 32'(btn_db), 32'd0);
            end
            btn = 4'b0000;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                check("bounce_btn_db", 32'(btn_db), 32'd0);
            end
        end
        press(4'b0010, 1);
        release_all();

        // Wrong button, then press with no mole
        set_mole(1'b1, 4'b0001);
        press(4'b0100, 2);
        release_all();
        set_mole(1'b0, 4'b0001);
        press(4'b0001, 2);
        release_all();

        // Lock: re-press on the same mole is ignored
        set_mole(1'b1, 4'b0001);
        press(4'b0001, 1);
        release_all();
        press(4'b0001, 0);
        release_all();
        set_mole(1'b1, 4'b0100);
        press(4'b0100, 1);
        release_all();

        // Simultaneous correct and wrong press
        set_mole(1'b1, 4'b1000);
        press(4'b1001, 1);
        release_all();

        // Async reset with a hit pending
        set_mole(1'b1, 4'b0010);
        @(negedge clk);
        btn = 4'b0010;
        wait_cyc(D + 2);
        check("pre_reset_btn_db", 32'(btn_db), 32'b0010);
        #2 reset = 1'b0;
        #1;
        check("async_reset_hit", 32'(hit), 32'd0);
        check("async_reset_miss", 32'(miss), 32'd0);
        check("async_reset_btn_db", 32'(btn_db), 32'd0);
        wait_cyc(3);
        reset = 1'b1;
        sb.push_back('{1'b1, edge_cnt + D + 3});
        wait_cyc(12);
        check("post_reset_btn_db", 32'(btn_db), 32'b0010);
        release_all();

        wait_cyc(4);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
